// File: rtl/tm_sch_pio_init_if.sv
// PIO bus bundle for the first-level scheduler memory bank initiator.
// Carries the host request/response handshake, the shared register bus
// (reg_addr/reg_din/reg_rd/reg_wr), the one-hot target select reg_ms and
// the per-target mem_ack/mem_rdata return path.
//   master : initiator view (tm_sch_pio_init)
//   slave  : host + memory-target view (environment)
interface tm_sch_pio_init_if #(
    parameter int unsigned PIO_NBITS = 32,
    parameter int unsigned NUM_TGT   = 6
);
    logic                           host_req_valid;
    logic                           host_req_ready;
    logic                           host_req_wr;
    logic [PIO_NBITS-1:0]           host_req_addr;
    logic [PIO_NBITS-1:0]           host_req_wdata;
    logic                           host_rsp_valid;
    logic [PIO_NBITS-1:0]           host_rsp_rdata;
    logic                           host_rsp_err;
    logic [PIO_NBITS-1:0]           reg_addr;
    logic [PIO_NBITS-1:0]           reg_din;
    logic                           reg_rd;
    logic                           reg_wr;
    logic [NUM_TGT-1:0]             reg_ms;
    logic [NUM_TGT-1:0]             mem_ack;
    logic [NUM_TGT*PIO_NBITS-1:0]   mem_rdata;

    modport master (
        input  host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
        input  mem_ack, mem_rdata,
        output host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
        output reg_addr, reg_din, reg_rd, reg_wr, reg_ms
    );

    modport slave (
        output host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
        output mem_ack, mem_rdata,
        input  host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
        input  reg_addr, reg_din, reg_rd, reg_wr, reg_ms
    );
endinterface

// File: rtl/tm_sch_pio_init.sv
// PIO initiator for the first-level scheduler memory bank.
// Takes one host register request at a time, decodes the target memory from
// host_req_addr[SEL_LSB +: SEL_NBITS], drives the shared register bus with a
// one-cycle rd/wr strobe and a held one-hot reg_ms, then returns a single
// one-cycle response carrying read data, or an error on decode miss/timeout.
// Ports:
//   clk    : clock
//   rst_ni : synchronous active-low reset
//   bus    : host request/response + register bus + per-target ack/rdata
module tm_sch_pio_init #(
    parameter int unsigned PIO_NBITS      = 32,
    parameter int unsigned NUM_TGT        = 6,
    parameter int unsigned SEL_LSB        = 16,
    parameter int unsigned SEL_NBITS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    tm_sch_pio_init_if.master     bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NUM_TGT-1:0]     ms_q, ms_d;
    logic [PIO_NBITS-1:0]   addr_q, addr_d;
    logic [PIO_NBITS-1:0]   din_q, din_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   is_wr_q, is_wr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [PIO_NBITS-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [SEL_NBITS-1:0]   req_sel;
    logic                   sel_ok;
    logic [NUM_TGT-1:0]     req_onehot;
    logic                   ack_hit;
    logic [PIO_NBITS-1:0]   sel_rdata;

    assign req_sel    = bus.host_req_addr[SEL_LSB +: SEL_NBITS];
    assign sel_ok     = (32'(req_sel) < NUM_TGT);
    assign req_onehot = NUM_TGT'(1) << req_sel;
    // ms_q is only non-zero during ACCESS, so this also drops acks seen in IDLE.
    assign ack_hit    = |(bus.mem_ack & ms_q);

    // One-hot AND-OR mux of the selected target's read data.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_TGT); i++) begin
            if (ms_q[i]) begin
                sel_rdata = sel_rdata | bus.mem_rdata[i*PIO_NBITS +: PIO_NBITS];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ms_d        = ms_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        is_wr_d     = is_wr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.host_req_valid) begin
                    if (sel_ok) begin
                        state_d = StAccess;
                        cnt_d   = '0;
                        ms_d    = req_onehot;
                        addr_d  = bus.host_req_addr;
                        din_d   = bus.host_req_wdata;
                        rd_d    = ~bus.host_req_wr;
                        wr_d    = bus.host_req_wr;
                        is_wr_d = bus.host_req_wr;
                    end else begin
                        // Decode miss: answer immediately, bus stays quiet.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q + CntW'(1);
                // Ack is checked before the timeout so a last-cycle ack still wins.
                if (ack_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = is_wr_q ? '0 : sel_rdata;
                    state_d     = StIdle;
                    cnt_d       = '0;
                    ms_d        = '0;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = StIdle;
                    cnt_d       = '0;
                    ms_d        = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ms_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            is_wr_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ms_q        <= ms_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            is_wr_q     <= is_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.host_req_ready = (state_q == StIdle) && rst_ni;
    assign bus.host_rsp_valid = rsp_valid_q;
    assign bus.host_rsp_rdata = rsp_rdata_q;
    assign bus.host_rsp_err   = rsp_err_q;
    assign bus.reg_addr       = addr_q;
    assign bus.reg_din        = din_q;
    assign bus.reg_rd         = rd_q;
    assign bus.reg_wr         = wr_q;
    assign bus.reg_ms         = ms_q;
endmodule
